// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI responder: conf bit positions and FSM states.
package spi_slave_pkg;

  localparam int CONF_CPHA = 0;
  localparam int CONF_CPOL = 1;
  localparam int CONF_LSB  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/spi_slave_sync_bit.sv
// Multi-flop synchroniser for one asynchronous input with a selectable reset value.
module spi_slave_sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage deeper every clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser chain register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversamples SCK/CS_n/MOSI in the clk domain, assembles received words for the CPU
// and shifts a CPU-loaded word (or an idle fill pattern) out on MISO. Modes 0-3, MSB/LSB first.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_FILL   = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [2:0]        conf,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_read,
  output logic              rx_overrun,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b1, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b1};
  endfunction

  function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  logic sck_s, cs_s, mosi_s;

  spi_slave_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(spi_clk), .q(sck_s)
  );
  spi_slave_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_s)
  );
  spi_slave_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
  );

  state_e                 state_q, state_d;
  logic [2:0]             mode_q, mode_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   done_q, done_d;
  logic                   sck_dly_q, sck_dly_d;
  // warm_q fills with ones after reset; once full, cs_s carries real pin history.
  logic [SYNC_STAGES-1:0] warm_q, warm_d;
  // armed_q: CS_n has been seen high since reset, so a low level is a genuine frame start.
  logic                   armed_q, armed_d;
  logic                   miso_q, miso_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic [DATA_W-1:0]      tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]      rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;

  logic              sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic [DATA_W-1:0] next_word;
  logic              consume;

  // Classify synchronised SCK transitions by the latched mode.
  always_comb begin
    sck_rise    = sck_s & ~sck_dly_q;
    sck_fall    = ~sck_s & sck_dly_q;
    lead_edge   = mode_q[CONF_CPOL] ? sck_fall : sck_rise;
    trail_edge  = mode_q[CONF_CPOL] ? sck_rise : sck_fall;
    sample_edge = mode_q[CONF_CPHA] ? trail_edge : lead_edge;
    shift_edge  = mode_q[CONF_CPHA] ? lead_edge : trail_edge;
  end

  // Frame FSM, shift registers, rx/tx buffers and sticky flags.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    sck_dly_d   = sck_s;
    warm_d      = {warm_q[SYNC_STAGES-2:0], 1'b1};
    armed_d     = armed_q | (warm_q[SYNC_STAGES-1] & cs_s);
    miso_d      = miso_q;
    tx_ready_d  = tx_ready_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    tx_buf_d    = tx_buf_q;
    consume     = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    next_word   = tx_ready_q ? IDLE_FILL : tx_buf_q;

    // Clears first so that a same-cycle set below takes precedence.
    if (err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (rx_read) begin
      rx_valid_d = 1'b0;
    end
    // A word completed on the previous cycle is published now.
    if (done_q) begin
      rx_data_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_read) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !cs_s) begin
          state_d = ST_SHIFT;
          mode_d  = conf;
          cnt_d   = '0;
          consume = 1'b1;
          if (conf[CONF_CPHA]) begin
            tx_sh_d = next_word;
          end else begin
            miso_d  = first_bit(next_word, conf[CONF_LSB]);
            tx_sh_d = drop_bit(next_word, conf[CONF_LSB]);
          end
        end
      end
      ST_SHIFT: begin
        if (cs_s) begin
          state_d = ST_IDLE;
          miso_d  = 1'b1;
          cnt_d   = '0;
          if ((cnt_q != '0) && !done_q) begin
            frame_err_d = 1'b1;
          end
        end else begin
          if (done_q) begin
            consume = 1'b1;
            tx_sh_d = next_word;
            cnt_d   = '0;
          end
          if (sample_edge) begin
            rx_sh_d = push_bit(rx_sh_q, mosi_s, mode_q[CONF_LSB]);
            cnt_d   = cnt_inc;
            done_d  = (cnt_inc == CNT_W'(DATA_W));
          end
          if (shift_edge) begin
            miso_d  = first_bit(tx_sh_q, mode_q[CONF_LSB]);
            tx_sh_d = drop_bit(tx_sh_q, mode_q[CONF_LSB]);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Buffer consume happens before a same-cycle CPU load.
    if (consume && !tx_ready_q) begin
      tx_ready_d = 1'b1;
    end
    if (tx_load && tx_ready_d) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 3'b000;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      sck_dly_q   <= 1'b0;
      warm_q      <= '0;
      armed_q     <= 1'b0;
      miso_q      <= 1'b1;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      sck_dly_q   <= sck_dly_d;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
      miso_q      <= miso_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Data registers; their contents are only consumed under control of the state above.
  always_ff @(posedge clk) begin
    tx_sh_q  <= tx_sh_d;
    rx_sh_q  <= rx_sh_d;
    tx_buf_q <= tx_buf_d;
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = (state_q == ST_SHIFT);
  assign busy        = (state_q == ST_SHIFT);
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = overrun_q;
  assign frame_err   = frame_err_q;

endmodule
